keccak_chi_masked_pipe: RTL and testbench

Pipelined, handshaked masked Keccak χ stage for arbitrary security order D, processing W parallel 5-bit rows per transfer. Each row is expanded with fresh randomness to (D+1)² shares per output bit, registered, then compressed back to D+1 shares and registered again. The result is a 2-cycle, glitch-safe masked χ slice that sits between the linear layer (θ/ρ/π) and ι in the round datapath. A bypass mode passes shares unchanged with identical latency.

---
 rtl/keccak_masked_pkg.sv | 34 +++
 rtl/keccak_chi_row_expand.sv | 40 ++++
 rtl/keccak_chi_masked_pipe.sv | 133 +++++++++++++
 tb/tb_keccak_chi_masked_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_masked_pkg.sv
// Sizing, lane naming and bit-layout helpers shared by the masked Keccak chi pipeline.
// Layouts: in_data bit ((l*W+w)*(D+1)+s); rnd word for row w, lane k, pair (i,j).
package keccak_masked_pkg;

  localparam int LANES = 5;

  typedef enum logic [2:0] {LANE_A, LANE_B, LANE_C, LANE_D, LANE_E} lane_e;

  function automatic int share_cnt(input int d);
    return d + 1;
  endfunction

  function automatic int mask_cnt(input int d);
    return d * (d + 1) / 2;
  endfunction

  // Packs the unordered pair {i,j}, i != j, into a dense triangular index.
  function automatic int mask_pair(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo + hi * (hi - 1) / 2;
  endfunction

  function automatic int in_idx(input int l, input int w, input int s, input int wd, input int d);
    return (l * wd + w) * share_cnt(d) + s;
  endfunction

  function automatic int rnd_idx(input int w, input int k, input int i, input int j, input int d);
    return (w * LANES + k) * mask_cnt(d) + mask_pair(i, j);
  endfunction

endpackage

// File: rtl/keccak_chi_row_expand.sv
// Combinational order-generic expansion of one chi row into (D+1)^2 shares per lane.
// Every share pair gets x_i*y_j, a symmetric zero-diagonal fresh mask, and one linear share.
module keccak_chi_row_expand
  import keccak_masked_pkg::*;
#(
  parameter int D = 5
) (
  input  logic [5*(D+1)-1:0]       row_in,
  input  logic [5*D*(D+1)/2-1:0]   rnd_row,
  output logic [5*(D+1)*(D+1)-1:0] exp_out
);

  localparam int S  = share_cnt(D);
  localparam int S2 = S * S;

  always_comb begin
    logic x;
    logic y;
    logic z;
    logic m;
    exp_out = '0;
    x = 1'b0;
    y = 1'b0;
    z = 1'b0;
    m = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < S; i++) begin
        for (int j = 0; j < S; j++) begin
          // Complementing only share 0 complements the recombined value exactly once.
          x = row_in[((k + 1) % LANES) * S + i] ^ (i == 0);
          y = row_in[((k + 2) % LANES) * S + j];
          z = (j == (i + k) % S) ? row_in[k * S + i] : 1'b0;
          m = (i != j) ? rnd_row[rnd_idx(0, k, i, j, D)] : 1'b0;
          exp_out[k * S2 + i * S + j] = (x & y) ^ z ^ m;
        end
      end
    end
  end

endmodule

// File: rtl/keccak_chi_masked_pipe.sv
// Two-stage handshaked masked Keccak chi slice: expand-and-register, then compress-and-register.
// Bypass mode carries the input shares through both registers untouched.
module keccak_chi_masked_pipe
  import keccak_masked_pkg::*;
#(
  parameter int D = 5,
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         chi_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [5*W*(D+1)-1:0]         in_data,
  input  logic                         rnd_valid,
  output logic                         rnd_ready,
  input  logic [5*W*D*(D+1)/2-1:0]     rnd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [5*W*(D+1)-1:0]         out_data,
  output logic                         busy
);

  localparam int S     = share_cnt(D);
  localparam int S2    = S * S;
  localparam int M     = mask_cnt(D);
  localparam int IN_W  = LANES * W * S;
  localparam int EXP_W = LANES * W * S2;

  logic [EXP_W-1:0] exp_d;
  logic [EXP_W-1:0] byp_d;
  logic [EXP_W-1:0] exp_p1;
  logic             mode_p1;
  logic             vld_p1;
  logic [IN_W-1:0]  cmp_d;
  logic [IN_W-1:0]  data_p2;
  logic             vld_p2;
  logic             capture;
  logic             advance;

  assign in_ready  = !vld_p1 || !vld_p2 || out_ready;
  assign capture   = in_valid && in_ready && (rnd_valid || !chi_en);
  assign advance   = vld_p1 && (!vld_p2 || out_ready);
  assign rnd_ready = capture && chi_en;
  assign busy      = vld_p1 || vld_p2;
  assign out_valid = vld_p2;
  assign out_data  = data_p2;

  for (genvar w = 0; w < W; w++) begin : g_row
    logic [LANES*S-1:0]  row_in;
    logic [LANES*S2-1:0] row_exp;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      for (genvar s = 0; s < S; s++) begin : g_share
        assign row_in[l*S+s] = in_data[in_idx(l, w, s, W, D)];
      end
      assign exp_d[(l*W+w)*S2 +: S2] = row_exp[l*S2 +: S2];
    end
    keccak_chi_row_expand #(.D(D)) u_expand (
      .row_in  (row_in),
      .rnd_row (rnd[w*LANES*M +: LANES*M]),
      .exp_out (row_exp)
    );
  end

  always_comb begin
    byp_d = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int w = 0; w < W; w++) begin
        byp_d[(l*W+w)*S2 +: S] = in_data[in_idx(l, w, 0, W, D) +: S];
      end
    end
  end

  // Stage 1: expanded (or bypassed) shares, loaded on capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (capture) begin
      vld_p1 <= 1'b1;
    end else if (advance) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_p1  <= '0;
      mode_p1 <= 1'b0;
    end else if (capture) begin
      exp_p1  <= chi_en ? exp_d : byp_d;
      mode_p1 <= chi_en;
    end
  end

  always_comb begin
    int base;
    base  = 0;
    cmp_d = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int w = 0; w < W; w++) begin
        for (int i = 0; i < S; i++) begin
          base = (l*W+w)*S2;
          cmp_d[in_idx(l, w, i, W, D)] = mode_p1 ? ^exp_p1[base + i*S +: S] : exp_p1[base + i];
        end
      end
    end
  end

  // Stage 2: compressed D+1 shares, loaded when stage 1 moves forward
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p2 <= 1'b1;
    end else if (out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p2 <= '0;
    end else if (advance) begin
      data_p2 <= cmp_d;
    end
  end

endmodule

// File: tb/tb_keccak_chi_masked_pipe.sv
// Directed bench for keccak_chi_masked_pipe: table of hand-computed chi rows plus
// hand-written sequences for stalls, randomness starvation, flush, reset and mask independence.
`timescale 1ns/1ps
module tb_keccak_chi_masked_pipe;

  localparam int D     = 5;
  localparam int W     = 8;
  localparam int S     = D + 1;
  localparam int M     = D * (D + 1) / 2;
  localparam int IN_W  = 5 * W * S;
  localparam int RND_W = 5 * W * M;
  localparam int RW    = 5 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush, chi_en, in_valid, rnd_valid, out_ready;
  logic             in_ready, rnd_ready, out_valid, busy;
  logic [IN_W-1:0]  in_data, out_data;
  logic [RND_W-1:0] rnd;

  logic             s_chi_en, s_in_valid, s_rnd_valid, s_out_ready;
  logic             s_in_ready, s_rnd_ready, s_out_valid, s_busy;
  logic [9:0]       s_in_data, s_out_data;
  logic [4:0]       s_rnd;

  keccak_chi_masked_pipe #(.D(D), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .chi_en(chi_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  keccak_chi_masked_pipe #(.D(1), .W(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .chi_en(s_chi_en),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .rnd_valid(s_rnd_valid), .rnd_ready(s_rnd_ready), .rnd(s_rnd),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] row;   // bit0=a .. bit4=e
    logic       chi;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic check_r(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_w(input string nm, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_n(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] chi_gold(input logic [4:0] v);
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[k] = v[k] ^ (~v[(k+1)%5] & v[(k+2)%5]);
    return r;
  endfunction

  function automatic logic [RW-1:0] gold_rows(input logic [RW-1:0] r);
    logic [RW-1:0] g;
    for (int w = 0; w < W; w++) g[w*5 +: 5] = chi_gold(r[w*5 +: 5]);
    return g;
  endfunction

  function automatic logic [RW-1:0] decode(input logic [IN_W-1:0] d);
    logic [RW-1:0] r;
    r = '0;
    for (int w = 0; w < W; w++)
      for (int l = 0; l < 5; l++)
        for (int s = 0; s < S; s++) r[w*5+l] = r[w*5+l] ^ d[(l*W+w)*S+s];
    return r;
  endfunction

  task automatic encode(input logic [RW-1:0] rows);
    logic acc, b;
    for (int w = 0; w < W; w++)
      for (int l = 0; l < 5; l++) begin
        acc = rows[w*5+l];
        for (int s = 0; s < S-1; s++) begin
          b = ($urandom_range(0, 1) != 0);
          in_data[(l*W+w)*S+s] = b;
          acc = acc ^ b;
        end
        in_data[(l*W+w)*S+S-1] = acc;
      end
  endtask

  task automatic rand_rnd();
    for (int i = 0; i < RND_W; i++) rnd[i] = ($urandom_range(0, 1) != 0);
  endtask

  function automatic logic [RW-1:0] rand_rows();
    logic [RW-1:0] r;
    for (int i = 0; i < RW; i++) r[i] = ($urandom_range(0, 1) != 0);
    return r;
  endfunction

  task automatic wait_out(input string nm, output logic ok);
    int n;
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    ok = out_valid;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got out_valid=0, want 1", nm);
    end
  endtask

  task automatic xfer(input string nm, input logic chi, output logic [IN_W-1:0] res, output logic ok);
    rand_rnd();
    chi_en = chi; in_valid = 1'b1; rnd_valid = chi; out_ready = 1'b1;
    @(negedge clk);
    check1({nm, "_rnd_ready"}, rnd_ready, chi);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    wait_out(nm, ok);
    res = out_data;
    @(posedge clk); #1;
  endtask

  task automatic fill_two();
    out_ready = 1'b0; chi_en = 1'b1; rnd_valid = 1'b1; in_valid = 1'b1;
    encode(rand_rows()); rand_rnd();
    @(posedge clk); #1;
    encode(rand_rows()); rand_rnd();
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
  endtask

  logic [IN_W-1:0] res_a, res_b, sent_data, held_data;
  logic [RW-1:0]   cur_rows, fix_rows;
  logic [RW-1:0]   exp_q[$];
  logic            ok, ok_b, stalled, fire_in, fire_out;
  int              sent, got, cyc, s_pulses;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{5'b00101, 1'b1, 5'b01100};
    tbl[1]  = '{5'b00000, 1'b1, 5'b00000};
    tbl[2]  = '{5'b11111, 1'b1, 5'b11111};
    tbl[3]  = '{5'b00010, 1'b1, 5'b10010};
    tbl[4]  = '{5'b00100, 1'b1, 5'b00101};
    tbl[5]  = '{5'b00001, 1'b1, 5'b01001};
    tbl[6]  = '{5'b01000, 1'b1, 5'b01010};
    tbl[7]  = '{5'b10000, 1'b1, 5'b10100};
    tbl[8]  = '{5'b00011, 1'b1, 5'b01011};
    tbl[9]  = '{5'b10110, 1'b1, 5'b00010};
    tbl[10] = '{5'b00101, 1'b0, 5'b00101};
    tbl[11] = '{5'b10110, 1'b0, 5'b10110};

    rst_n = 1'b0; flush = 1'b0; chi_en = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
    out_ready = 1'b0; in_data = '0; rnd = '0;
    s_chi_en = 1'b0; s_in_valid = 1'b0; s_rnd_valid = 1'b0; s_out_ready = 1'b1;
    s_in_data = '0; s_rnd = '0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check_w("rst_out_data", out_data, '0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_rnd_ready", rnd_ready, 1'b0);
    check1("rst_s_out_valid", s_out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // D=1, W=1: (a,b,c,d,e)=(1,0,1,0,0) -> (0,0,1,1,0)
    for (int l = 0; l < 5; l++) begin
      s_in_data[l*2] = ($urandom_range(0, 1) != 0);
      s_in_data[l*2+1] = s_in_data[l*2] ^ (l == 0 || l == 2);
    end
    for (int i = 0; i < 5; i++) s_rnd[i] = ($urandom_range(0, 1) != 0);
    s_chi_en = 1'b1; s_in_valid = 1'b1; s_rnd_valid = 1'b1;
    s_pulses = 0;
    @(negedge clk); if (s_rnd_ready) s_pulses++;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_rnd_valid = 1'b0;
    check1("s_lat1", s_out_valid, 1'b0);
    @(negedge clk); if (s_rnd_ready) s_pulses++;
    @(posedge clk); #1;
    check1("s_lat2", s_out_valid, 1'b1);
    n_cmp++;
    if ({s_out_data[8]^s_out_data[9], s_out_data[6]^s_out_data[7], s_out_data[4]^s_out_data[5],
         s_out_data[2]^s_out_data[3], s_out_data[0]^s_out_data[1]} !== 5'b01100) begin
      n_bad++;
      $display("FAIL s_chi: got shares %b, want recombined 01100", s_out_data);
    end
    @(negedge clk); if (s_rnd_ready) s_pulses++;
    check_n("s_rnd_pulses", s_pulses, 1);

    // Table vectors, every row of the transfer carries the same pattern
    for (int t = 0; t < 12; t++) begin
      encode({W{tbl[t].row}});
      sent_data = in_data;
      xfer("tbl", tbl[t].chi, res_a, ok);
      if (ok) begin
        check_r("tbl_rows", decode(res_a), {W{tbl[t].exp}});
        if (!tbl[t].chi) check_w("tbl_bypass", res_a, sent_data);
      end
    end

    // Bypass with random shares and no randomness offered
    encode(rand_rows());
    sent_data = in_data;
    xfer("byp", 1'b0, res_a, ok);
    if (ok) check_w("byp_data", res_a, sent_data);

    // 100 back-to-back transfers under random backpressure
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    cur_rows = rand_rows(); encode(cur_rows); rand_rnd();
    chi_en = 1'b1; rnd_valid = 1'b1; in_valid = 1'b1;
    while (got < 100 && cyc < 3000) begin
      out_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (stalled) begin
        check1("stall_valid", out_valid, 1'b1);
        check_w("stall_hold", out_data, held_data);
      end
      fire_in = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      held_data = out_data;
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stream_extra: got unexpected output %h, want none", decode(out_data));
        end else begin
          check_r("stream_row", decode(out_data), exp_q.pop_front());
        end
        got++;
      end
      if (fire_in) begin
        exp_q.push_back(gold_rows(cur_rows));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (fire_in) begin
        if (sent < 100) begin
          cur_rows = rand_rows(); encode(cur_rows); rand_rnd();
        end else begin
          in_valid = 1'b0; rnd_valid = 1'b0;
        end
      end
    end
    check_n("stream_count", got, 100);
    check_n("stream_left", exp_q.size(), 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Randomness starvation: no capture until rnd_valid rises
    encode({W{5'b00101}}); rand_rnd();
    chi_en = 1'b1; in_valid = 1'b1; rnd_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check1("rs_in_ready", in_ready, 1'b1);
      check1("rs_rnd_ready", rnd_ready, 1'b0);
      @(posedge clk); #1;
      check1("rs_busy", busy, 1'b0);
    end
    rnd_valid = 1'b1;
    @(negedge clk);
    check1("rs_take", rnd_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    check1("rs_busy1", busy, 1'b1);
    check1("rs_lat1", out_valid, 1'b0);
    @(posedge clk); #1;
    check1("rs_lat2", out_valid, 1'b1);
    check_r("rs_data", decode(out_data), {W{5'b01100}});
    @(posedge clk); #1;
    check1("rs_drained", busy, 1'b0);

    // Full pipeline, then flush
    fill_two();
    check1("fl_in_ready", in_ready, 1'b0);
    check1("fl_full_valid", out_valid, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check1("fl_out_valid", out_valid, 1'b0);
    check1("fl_busy", busy, 1'b0);
    cur_rows = rand_rows(); encode(cur_rows); rand_rnd();
    chi_en = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    check1("fl_lat1", out_valid, 1'b0);
    @(posedge clk); #1;
    check1("fl_lat2", out_valid, 1'b1);
    check_r("fl_data", decode(out_data), gold_rows(cur_rows));
    @(posedge clk); #1;

    // Reset mid-stream, asserted together with flush
    fill_two();
    rst_n = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    check1("mr_out_valid", out_valid, 1'b0);
    check_w("mr_out_data", out_data, '0);
    check1("mr_busy", busy, 1'b0);
    check1("mr_in_ready", in_ready, 1'b1);
    check1("mr_rnd_ready", rnd_ready, 1'b0);
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check1("mr_no_output", out_valid, 1'b0);
    end

    // Same input shares, different masks
    fix_rows = rand_rows(); encode(fix_rows);
    xfer("ind_a", 1'b1, res_a, ok);
    xfer("ind_b", 1'b1, res_b, ok_b);
    if (ok && ok_b) begin
      check_r("ind_a_val", decode(res_a), gold_rows(fix_rows));
      check_r("ind_b_val", decode(res_b), gold_rows(fix_rows));
      check1("ind_vary", res_a !== res_b, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
